// File: rtl/pipeline_stall_ctrl.sv
// Pipeline sequencing controller: stage enables, flush/bubble, EX forwarding
// selects, multi-cycle mult/div hold, halt state and a stall-cycle counter.
module pipeline_stall_ctrl #(
  parameter int unsigned MD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] haz,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic        md_start,
  input  logic        halt,
  output logic        pc_en,
  output logic        s1_en,
  output logic        s1_flush,
  output logic        s2_en,
  output logic        s2_bubble,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [1:0]  fwd_sd,
  output logic [1:0]  fwd_r0,
  output logic        md_busy,
  output logic        halted,
  output logic [15:0] stall_cnt
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned FWD_W  = 2;
  localparam int unsigned SCNT_W = 16;
  localparam logic [CNT_W-1:0]  MD_LOAD  = (MD_CYCLES > 1) ? CNT_W'(MD_CYCLES - 2) : '0;
  localparam logic [SCNT_W-1:0] SCNT_MAX = '1;

  typedef enum logic [1:0] {RUN, MD_BUSY, HALTED} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [FWD_W-1:0] fwd_a_d, fwd_b_d, fwd_sd_d, fwd_r0_d;

  // haz[5:4] feed the branch comparator directly
  logic unused_haz;
  assign unused_haz = ^haz[5:4];

  assign md_busy = (state == MD_BUSY);
  assign halted  = (state == HALTED);

  // Stage controls decoded from state and this cycle's requests
  always_comb begin
    pc_en     = 1'b0;
    s1_en     = 1'b0;
    s2_en     = 1'b0;
    s1_flush  = 1'b0;
    s2_bubble = 1'b0;
    if (rst) begin
      s2_bubble = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (md_start) begin
            pc_en = 1'b1; s1_en = 1'b1; s2_en = 1'b1;
          end else if (branch_taken) begin
            pc_en = 1'b1; s1_en = 1'b1; s2_en = 1'b1;
            s1_flush = 1'b1; s2_bubble = 1'b1;
          end else if (halt) begin
            s2_bubble = 1'b1;
          end else if (stall) begin
            s2_en = 1'b1; s2_bubble = 1'b1;
          end else begin
            pc_en = 1'b1; s1_en = 1'b1; s2_en = 1'b1;
          end
        end
        HALTED:  s2_bubble = 1'b1;
        default: ;
      endcase
    end
  end

  // Forwarding selects for the instruction entering ID/EX
  always_comb begin
    fwd_a_d  = 2'b00;
    fwd_b_d  = 2'b00;
    fwd_sd_d = 2'b00;
    fwd_r0_d = 2'b00;
    if (!s2_bubble) begin
      fwd_a_d  = haz[1]  ? 2'b01 : haz[0] ? 2'b10 : 2'b00;
      fwd_b_d  = haz[2]  ? 2'b01 : haz[3] ? 2'b10 : 2'b00;
      fwd_sd_d = haz[10] ? 2'b01 : haz[8] ? 2'b10 : haz[9] ? 2'b11 : 2'b00;
      fwd_r0_d = haz[6]  ? 2'b01 : haz[7] ? 2'b10 : 2'b00;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      cnt       <= '0;
      fwd_a     <= '0;
      fwd_b     <= '0;
      fwd_sd    <= '0;
      fwd_r0    <= '0;
      stall_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (md_start) begin
            if (MD_CYCLES > 1) begin
              state <= MD_BUSY;
              cnt   <= MD_LOAD;
            end
          end else if (!branch_taken && halt) begin
            state <= HALTED;
          end
        end
        MD_BUSY: begin
          if (cnt == '0) state <= RUN;
          else           cnt   <= cnt - CNT_W'(1);
        end
        HALTED:  ;
        default: state <= RUN;
      endcase

      if (s2_en) begin
        fwd_a  <= fwd_a_d;
        fwd_b  <= fwd_b_d;
        fwd_sd <= fwd_sd_d;
        fwd_r0 <= fwd_r0_d;
      end

      // Halted cycles are not stalls; saturate rather than wrap
      if (!pc_en && state != HALTED && stall_cnt != SCNT_MAX)
        stall_cnt <= stall_cnt + SCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: inputs change on the falling edge,
// combinational outputs checked 1ns later, registered ones 1ns after posedge.
module tb_pipeline_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] haz;
  logic        stall, branch_taken, md_start, halt;
  logic        pc_en, s1_en, s1_flush, s2_en, s2_bubble;
  logic [1:0]  fwd_a, fwd_b, fwd_sd, fwd_r0;
  logic        md_busy, halted;
  logic [15:0] stall_cnt;

  int vectors = 0;
  int miscompares = 0;
  int exp_cnt = 0;

  pipeline_stall_ctrl #(.MD_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .haz(haz), .stall(stall),
    .branch_taken(branch_taken), .md_start(md_start), .halt(halt),
    .pc_en(pc_en), .s1_en(s1_en), .s1_flush(s1_flush), .s2_en(s2_en),
    .s2_bubble(s2_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_sd(fwd_sd),
    .fwd_r0(fwd_r0), .md_busy(md_busy), .halted(halted), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    haz = '0; stall = 0; branch_taken = 0; md_start = 0; halt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    idle_inputs();
    @(negedge clk);
    rst = 0;
    exp_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    @(negedge clk); #1;
    vectors++;
    if ({pc_en, s1_en, s2_en, s1_flush, s2_bubble} !== 5'b00001) begin
      miscompares++;
      $display("FAIL reset_ctrl got=%b want=00001", {pc_en, s1_en, s2_en, s1_flush, s2_bubble});
    end
    vectors++;
    if ({fwd_a, fwd_b, fwd_sd, fwd_r0, stall_cnt, md_busy, halted} !== 26'd0) begin
      miscompares++;
      $display("FAIL reset_regs fwd=%b cnt=%h busy=%b halted=%b want 0", {fwd_a, fwd_b, fwd_sd, fwd_r0}, stall_cnt, md_busy, halted);
    end
    @(negedge clk);
    rst = 0;
    #1;
    vectors++;
    if ({pc_en, s1_en, s2_en, s1_flush, s2_bubble} !== 5'b11100) begin
      miscompares++;
      $display("FAIL reset_release got=%b want=11100", {pc_en, s1_en, s2_en, s1_flush, s2_bubble});
    end
    @(posedge clk); #1;
    vectors++;
    if (stall_cnt !== 16'd0 || {fwd_a, fwd_b, fwd_sd, fwd_r0} !== 8'd0) begin
      miscompares++;
      $display("FAIL idle_regs cnt=%h fwd=%b want 0", stall_cnt, {fwd_a, fwd_b, fwd_sd, fwd_r0});
    end
  endtask

  task automatic test_stall();
    @(negedge clk);
    stall = 1; haz = 11'b000_0000_0011;
    #1;
    vectors++;
    if ({pc_en, s1_en, s2_en, s1_flush, s2_bubble} !== 5'b00101) begin
      miscompares++;
      $display("FAIL stall_ctrl got=%b want=00101", {pc_en, s1_en, s2_en, s1_flush, s2_bubble});
    end
    exp_cnt++;
    @(negedge clk);
    stall = 0; haz = '0;
    #1;
    vectors++;
    if ({pc_en, s1_en, s2_en, s2_bubble} !== 4'b1110 || stall_cnt !== 16'(exp_cnt)) begin
      miscompares++;
      $display("FAIL stall_after en=%b cnt=%0d want en=1110 cnt=%0d", {pc_en, s1_en, s2_en, s2_bubble}, stall_cnt, exp_cnt);
    end
    vectors++;
    if ({fwd_a, fwd_b, fwd_sd, fwd_r0} !== 8'd0) begin
      miscompares++;
      $display("FAIL stall_bubble_fwd got=%b want=0", {fwd_a, fwd_b, fwd_sd, fwd_r0});
    end
  endtask

  task automatic test_forwarding();
    logic [10:0] hv [5];
    logic [7:0]  ev [5];
    hv[0] = 11'b000_0000_0011; ev[0] = 8'b01_00_00_00;
    hv[1] = 11'b100_0000_1000; ev[1] = 8'b00_10_01_00;
    hv[2] = 11'b000_1100_0101; ev[2] = 8'b10_01_00_01;
    hv[3] = 11'b011_1011_0000; ev[3] = 8'b00_00_10_10;
    hv[4] = 11'b010_0011_0000; ev[4] = 8'b00_00_11_00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      haz = hv[i];
      @(posedge clk); #1;
      vectors++;
      if ({fwd_a, fwd_b, fwd_sd, fwd_r0} !== ev[i]) begin
        miscompares++;
        $display("FAIL fwd_vec%0d got=%b want=%b", i, {fwd_a, fwd_b, fwd_sd, fwd_r0}, ev[i]);
      end
    end
  endtask

  task automatic test_md_busy();
    @(negedge clk);
    md_start = 1; haz = 11'b000_0000_0011;
    #1;
    vectors++;
    if ({pc_en, s1_en, s2_en, md_busy} !== 4'b1110) begin
      miscompares++;
      $display("FAIL md_start_cycle got=%b want=1110", {pc_en, s1_en, s2_en, md_busy});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      md_start = 0; haz = 11'b000_0000_0100;
      branch_taken = (i == 0);
      #1;
      vectors++;
      if ({md_busy, pc_en, s1_en, s2_en, s1_flush, s2_bubble} !== 6'b100000 || fwd_a !== 2'b01 || fwd_b !== 2'b00) begin
        miscompares++;
        $display("FAIL md_hold%0d ctrl=%b fwd_a=%b fwd_b=%b want 100000/01/00", i, {md_busy, pc_en, s1_en, s2_en, s1_flush, s2_bubble}, fwd_a, fwd_b);
      end
      exp_cnt++;
    end
    @(negedge clk);
    branch_taken = 0; haz = '0;
    #1;
    vectors++;
    if (md_busy !== 1'b0 || pc_en !== 1'b1 || stall_cnt !== 16'(exp_cnt)) begin
      miscompares++;
      $display("FAIL md_done busy=%b pc_en=%b cnt=%0d want 0/1/%0d", md_busy, pc_en, stall_cnt, exp_cnt);
    end
  endtask

  task automatic test_md_async_reset();
    do_reset();
    @(negedge clk);
    md_start = 1;
    @(negedge clk);
    md_start = 0;
    #1;
    rst = 1;
    #1;
    vectors++;
    if (md_busy !== 1'b0 || stall_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL md_async_rst busy=%b cnt=%0d want 0/0", md_busy, stall_cnt);
    end
    @(negedge clk);
    rst = 0;
    exp_cnt = 0;
  endtask

  task automatic test_priority_halt();
    @(negedge clk);
    branch_taken = 1; halt = 1; stall = 1; haz = 11'b000_0000_0011;
    #1;
    vectors++;
    if ({pc_en, s1_en, s2_en, s1_flush, s2_bubble} !== 5'b11111) begin
      miscompares++;
      $display("FAIL branch_prio got=%b want=11111", {pc_en, s1_en, s2_en, s1_flush, s2_bubble});
    end
    @(posedge clk); #1;
    vectors++;
    if (halted !== 1'b0 || fwd_a !== 2'b00 || stall_cnt !== 16'(exp_cnt)) begin
      miscompares++;
      $display("FAIL branch_after halted=%b fwd_a=%b cnt=%0d want 0/00/%0d", halted, fwd_a, stall_cnt, exp_cnt);
    end
    @(negedge clk);
    branch_taken = 0; stall = 0; halt = 1;
    #1;
    vectors++;
    if ({pc_en, s1_en, s2_en, s1_flush, s2_bubble, halted} !== 6'b000010) begin
      miscompares++;
      $display("FAIL halt_cycle got=%b want=000010", {pc_en, s1_en, s2_en, s1_flush, s2_bubble, halted});
    end
    exp_cnt++;
    @(negedge clk);
    halt = 0;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (halted !== 1'b1 || pc_en !== 1'b0 || s2_bubble !== 1'b1 || stall_cnt !== 16'(exp_cnt)) begin
      miscompares++;
      $display("FAIL halted_hold halted=%b pc_en=%b bub=%b cnt=%0d want 1/0/1/%0d", halted, pc_en, s2_bubble, stall_cnt, exp_cnt);
    end
    #2;
    rst = 1;
    #1;
    vectors++;
    if (halted !== 1'b0 || stall_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL halt_async_rst halted=%b cnt=%0d want 0/0", halted, stall_cnt);
    end
    @(negedge clk);
    rst = 0;
    exp_cnt = 0;
  endtask

  task automatic test_saturation();
    do_reset();
    @(negedge clk);
    stall = 1;
    repeat (65534) @(posedge clk);
    #1;
    vectors++;
    if (stall_cnt !== 16'hFFFE) begin
      miscompares++;
      $display("FAIL sat_pre got=%h want=fffe", stall_cnt);
    end
    repeat (6) @(posedge clk);
    #1;
    vectors++;
    if (stall_cnt !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL sat_hold got=%h want=ffff", stall_cnt);
    end
    @(negedge clk);
    stall = 0;
  endtask

  initial begin
    test_reset();
    test_stall();
    test_forwarding();
    test_md_busy();
    test_md_async_reset();
    test_priority_halt();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Pipeline sequencing controller sitting directly downstream of `control_hazard_unit`. It consumes the 11-bit hazard vector and load-use `stall`, plus branch-resolution, multiply/divide-issue and halt events. From these it drives per-stage register enables, flush/bubble controls and registered EX-stage forwarding selects. It owns the multi-cycle mult/div hold and the halted state, and keeps a saturating stall-cycle performance counter.

## Interface
- `MD_CYCLES`, 4, cycles a MULT/DIV occupies EX; legal 1..15
- `clk` in 1, single clock, rising edge
- `rst` in 1, asynchronous, active-high reset
- `haz` in 11, hazard vector from `control_hazard_unit`
- `stall` in 1, load-use stall request from `control_hazard_unit`
- `branch_taken` in 1, branch in EX resolved taken
- `md_start` in 1, MULT/DIV entering EX this cycle
- `halt` in 1, HALT opcode decoded in ID
- `pc_en` out 1, PC register load enable
- `s1_en` out 1, IF/ID register enable
- `s1_flush` out 1, clear IF/ID to NOP
- `s2_en` out 1, ID/EX register enable
- `s2_bubble` out 1, load NOP control into ID/EX
- `fwd_a` out 2, EX operand A (R1) select: 00 regfile, 01 EX/MEM, 10 MEM/WB
- `fwd_b` out 2, EX operand B (R2) select, same encoding
- `fwd_sd` out 2, store-data select: 00 regfile, 01 EX/MEM ALU, 10 load data, 11 MEM/WB
- `fwd_r0` out 2, branch R0 compare select: 00 regfile, 01 EX/MEM, 10 MEM/WB
- `md_busy` out 1, high in MD_BUSY
- `halted` out 1, high in HALTED
- `stall_cnt` out 16, saturating stall-cycle counter

## Operation
- States: RUN, MD_BUSY, HALTED. 4-bit down-counter `cnt`.
- Outputs are combinational from state and inputs. Forwarding selects, `cnt` and `stall_cnt` are registers.
- RUN priority, highest first:
  - `md_start`: if MD_CYCLES>1, go to MD_BUSY with `cnt`=MD_CYCLES-2; otherwise stay in RUN. All enables are 1 this cycle.
  - `branch_taken`: `pc_en`=1, `s1_en`=1, `s1_flush`=1, `s2_en`=1, `s2_bubble`=1. Masks `halt` and `stall`. Stay in RUN.
  - `halt`: all enables 0, `s2_bubble`=1, go to HALTED.
  - `stall`: `pc_en`=0, `s1_en`=0, `s2_en`=1, `s2_bubble`=1. Stay in RUN.
  - Otherwise: all enables 1, `s1_flush`=0, `s2_bubble`=0.
- `md_start` together with `branch_taken` is a protocol error; `md_start` wins.
- MD_BUSY:
  - `pc_en`=`s1_en`=`s2_en`=0, `s2_bubble`=0, `s1_flush`=0.
  - `branch_taken`, `stall`, `halt` and `md_start` are ignored. A pending halt stays held in ID and is taken after return to RUN.
  - `cnt` decrements each cycle; at `cnt`==0 go to RUN.
- HALTED: all enables 0, `s2_bubble`=1. Exits only on `rst`.
- Forwarding registers load when `s2_en`=1:
  - If `s2_bubble`=1, all load 00.
  - Otherwise:
    - `fwd_a` = `haz[1]`?01 : `haz[0]`?10 : 00
    - `fwd_b` = `haz[2]`?01 : `haz[3]`?10 : 00
    - `fwd_sd` = `haz[10]`?01 : `haz[8]`?10 : `haz[9]`?11 : 00
    - `fwd_r0` = `haz[6]`?01 : `haz[7]`?10 : 00
  - They hold when `s2_en`=0.
  - `haz[4]` and `haz[5]` are decoded by the branch comparator and not consumed here.
- `stall_cnt` increments on each clock where `pc_en`=0 and state≠HALTED. It saturates at 16'hFFFF with no wrap.

## Timing
- While `rst`=1: state=RUN, `cnt`=0, all fwd=00, `stall_cnt`=0. `pc_en`, `s1_en`, `s2_en` and `s1_flush` are forced 0, and `s2_bubble` is forced 1.
- First active cycle after `rst` deasserts: normal RUN outputs.
- Load-use stall costs 1 cycle per cycle `stall` is high, with zero added latency. The freeze is in the same cycle `stall` is asserted.
- A taken branch flushes IF/ID and ID/EX in the same cycle, giving a 2-slot penalty.
- MULT/DIV holds the pipeline for exactly MD_CYCLES-1 cycles after the `md_start` cycle.
- `rst` mid-MD_BUSY or in HALTED returns to RUN immediately, asynchronously.
- Forwarding selects are valid in the cycle after the instruction enters ID/EX.

## Test plan
- Reset then idle: during `rst` the outputs are enables=0 and `s2_bubble`=1. After release, `pc_en`=`s1_en`=`s2_en`=1, fwd=00, `stall_cnt`=0.
- `stall`=1 for one cycle: that cycle `pc_en`=0, `s1_en`=0, `s2_bubble`=1. The next cycle is all enables 1 with `stall_cnt`=1 and all fwd=00.
- `haz`=11'b000_0000_0011: after the edge, `fwd_a`=01 and `fwd_b`=00. `haz`=11'b100_0000_1000: `fwd_b`=10 and `fwd_sd`=01.
- MD_CYCLES=4 with `md_start` pulse: `md_busy` is high for 3 cycles with all enables 0. `branch_taken` asserted mid-busy is ignored. `stall_cnt`=3 afterwards.
- `branch_taken`, `halt` and `stall` together in RUN: `s1_flush`=1, `s2_bubble`=1, `pc_en`=1, and the state stays RUN. `halt` alone then gives `halted`=1 until `rst`.
- Force 65 540 stall cycles: `stall_cnt` holds at 16'hFFFF with no wrap.
